picosoc_iomem_timer: RTL and testbench

Memory-mapped down-counting timer that answers the SoC's external `iomem` bus, acting as the responder to the CPU-side initiator. It provides a 32-bit counter with reload and an interrupt request, and sits outside the SoC top. Its `irq` output is wired to one of the SoC's external interrupt inputs, normally `irq_5`.

---
 rtl/picosoc_iomem_timer.sv | 177 +++++++++++++++++
 tb/tb_picosoc_iomem_timer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_iomem_timer.sv
// Down-counting 32-bit timer on the picosoc iomem bus with reload and irq.
// Define PICOSOC_IOMEM_TIMER_PRESCALE_EN to add the 16-bit PRESCALE register.
module picosoc_iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] reload;
  logic        exp_flag;

  logic        en;
  logic        ar;
  logic        ie;
  assign en = ctrl[0];
  assign ar = ctrl[1];
  assign ie = ctrl[2];

  logic        sel;
  logic        acc;
  logic        wr;
  logic [5:0]  off;
  logic [31:0] wmask;
  logic        unused_addr;

  assign sel = iomem_valid &&
               (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign acc = sel && !iomem_ready;
  assign wr  = acc && (iomem_wstrb != 4'b0000);
  assign off = iomem_addr[7:2];
  assign unused_addr = ^iomem_addr[1:0];

  assign wmask = {{8{iomem_wstrb[3]}},
                  {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}},
                  {8{iomem_wstrb[0]}}};

  function automatic logic [31:0] merge(
    input logic [31:0] old
  );
    return (old & ~wmask) | (iomem_wdata & wmask);
  endfunction

  logic wr_ctrl;
  logic wr_count;
  logic wr_reload;
  logic wr_status;
  logic wr_pre;

  always_comb begin
    wr_ctrl   = 1'b0;
    wr_count  = 1'b0;
    wr_reload = 1'b0;
    wr_status = 1'b0;
    wr_pre    = 1'b0;
    if (wr) begin
      unique case (off)
        6'h00:   wr_ctrl   = 1'b1;
        6'h01:   wr_count  = 1'b1;
        6'h02:   wr_reload = 1'b1;
        6'h03:   wr_status = 1'b1;
        6'h04:   wr_pre    = 1'b1;
        default: ;
      endcase
    end
  end

  logic tick;

`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] pcnt;

  assign tick = en && (pcnt == prescale);

  // Counter restarts from zero on any PRESCALE write or while stopped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescale <= 16'h0000;
      pcnt     <= 16'h0000;
    end else begin
      if (wr_pre) begin
        if (iomem_wstrb[0])
          prescale[7:0] <= iomem_wdata[7:0];
        if (iomem_wstrb[1])
          prescale[15:8] <= iomem_wdata[15:8];
      end
      if (!en || wr_pre || tick)
        pcnt <= 16'h0000;
      else
        pcnt <= pcnt + 16'd1;
    end
  end
`else
  logic unused_pre;
  assign unused_pre = wr_pre;
  assign tick = en;
`endif

  logic [31:0] count_nxt;
  logic        expire;
  logic        en_clr;

  always_comb begin
    count_nxt = count;
    expire    = 1'b0;
    en_clr    = 1'b0;
    if (tick) begin
      if (count > 32'd1) begin
        count_nxt = count - 32'd1;
      end else if (count == 32'd1) begin
        expire    = 1'b1;
        count_nxt = ar ? reload : 32'd0;
        en_clr    = !ar;
      end
    end
    // A CPU write overrides the same-cycle decrement.
    if (wr_count)
      count_nxt = merge(count);
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    unique case (off)
      6'h00:   rd_mux = {29'd0, ctrl};
      6'h01:   rd_mux = count;
      6'h02:   rd_mux = reload;
      6'h03:   rd_mux = {31'd0, exp_flag};
`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
      6'h04:   rd_mux = {16'd0, prescale};
`endif
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
      irq         <= 1'b0;
      ctrl        <= 3'd0;
      count       <= 32'd0;
      reload      <= 32'd0;
      exp_flag    <= 1'b0;
    end else begin
      iomem_ready <= acc;
      iomem_rdata <= acc ? rd_mux : 32'd0;
      irq         <= exp_flag & ie;
      count       <= count_nxt;
      if (wr_ctrl && iomem_wstrb[0])
        ctrl <= iomem_wdata[2:0];
      else if (en_clr)
        ctrl[0] <= 1'b0;
      if (wr_reload)
        reload <= merge(reload);
      // Expiry beats a same-cycle write-1-to-clear.
      if (expire)
        exp_flag <= 1'b1;
      else if (wr_status && iomem_wstrb[0] &&
               iomem_wdata[0])
        exp_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Bench for picosoc_iomem_timer: vector table, corner sequences,
// and random bus traffic against a cycle-level reference model.
module tb_picosoc_iomem_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_CNT  = BASE + 32'h04;
  localparam logic [31:0] A_RLD  = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_PRE  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        irq;

  picosoc_iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .resetn(resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_count;
  logic [31:0] m_reload;
  logic        m_exp;
  logic [15:0] m_pre;
  logic [15:0] m_pcnt;
  logic        m_ready;

  logic        last_rdy;
  logic [31:0] last_rd;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h",
               name, $time, act, want);
    end
  endtask

  function automatic logic [31:0] bytemerge(
    input logic [31:0] old, input logic [31:0] wd,
    input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++)
      if (ws[n]) r[8*n +: 8] = wd[8*n +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [5:0] off);
    case (off)
      6'h00: return {29'd0, m_ctrl};
      6'h01: return m_count;
      6'h02: return m_reload;
      6'h03: return {31'd0, m_exp};
`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
      6'h04: return {16'd0, m_pre};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'd0; m_count = 32'd0; m_reload = 32'd0;
    m_exp = 1'b0; m_pre = 16'd0; m_pcnt = 16'd0;
    m_ready = 1'b0;
  endtask

  task automatic model_advance(input logic w,
                               input logic [5:0] off,
                               input logic [31:0] wd,
                               input logic [3:0] ws);
    logic tick, expired;
    logic [31:0] c, r, tmp;
    logic [2:0] ct;
    logic ex;
    logic [15:0] p, pc;
    c = m_count; r = m_reload; ct = m_ctrl;
    ex = m_exp; p = m_pre; pc = m_pcnt;
`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
    tick = m_ctrl[0] && (m_pcnt == m_pre);
    pc = (!m_ctrl[0] || tick) ? 16'd0 : m_pcnt + 16'd1;
`else
    tick = m_ctrl[0];
`endif
    expired = 1'b0;
    if (tick && m_count == 32'd1) begin
      expired = 1'b1;
      ex = 1'b1;
      if (m_ctrl[1]) c = m_reload;
      else begin c = 32'd0; ct[0] = 1'b0; end
    end else if (tick && m_count != 32'd0) begin
      c = m_count - 32'd1;
    end
    if (w) begin
      case (off)
        6'h00: if (ws[0]) ct = wd[2:0];
        6'h01: c = bytemerge(m_count, wd, ws);
        6'h02: r = bytemerge(m_reload, wd, ws);
        6'h03: if (ws[0] && wd[0] && !expired) ex = 1'b0;
`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
        6'h04: begin
          tmp = bytemerge({16'd0, m_pre}, wd, ws);
          p = tmp[15:0];
          pc = 16'd0;
        end
`endif
        default: ;
      endcase
    end
    m_count = c; m_reload = r; m_ctrl = ct;
    m_exp = ex; m_pre = p; m_pcnt = pc;
  endtask

  // One clock: drive at negedge, predict, sample #1 after posedge.
  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] ws);
    logic acc, e_rdy, e_irq;
    logic [31:0] e_rd;
    iomem_valid = v; iomem_addr = a;
    iomem_wdata = wd; iomem_wstrb = ws;
    if (!resetn) begin
      e_rdy = 1'b0; e_rd = 32'd0; e_irq = 1'b0;
      model_reset();
    end else begin
      acc = v && (a[31:8] == BASE[31:8]) && !m_ready;
      e_rdy = acc;
      e_rd = acc ? mread(a[7:2]) : 32'd0;
      e_irq = m_exp && m_ctrl[2];
      model_advance(acc && (ws != 4'd0), a[7:2], wd, ws);
      m_ready = acc;
    end
    @(posedge clk); #1;
    last_rdy = iomem_ready;
    last_rd = iomem_rdata;
    check("ready", 32'(iomem_ready), 32'(e_rdy));
    check("rdata", iomem_rdata, e_rd);
    check("irq", 32'(irq), 32'(e_irq));
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d, 4'hF);
    idle();
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic [31:0] want);
    step(1'b1, a, 32'd0, 4'd0);
    check(name, last_rd, want);
    idle();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    idle();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rdy;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[18];
  logic [31:0] pre_rb;

  initial begin
    #1_000_000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
    pre_rb = 32'h0000_1234;
`else
    pre_rb = 32'h0000_0000;
`endif
    tbl[0]  = '{A_CTRL, 32'h0, 4'h0, 1'b1, 32'h0};
    tbl[1]  = '{A_CNT,  32'h0, 4'h0, 1'b1, 32'h0};
    tbl[2]  = '{A_RLD,  32'h0, 4'h0, 1'b1, 32'h0};
    tbl[3]  = '{A_STAT, 32'h0, 4'h0, 1'b1, 32'h0};
    tbl[4]  = '{A_PRE,  32'h0, 4'h0, 1'b1, 32'h0};
    tbl[5]  = '{A_CNT, 32'h1122_3344, 4'hF, 1'b1, 32'h0};
    tbl[6]  = '{A_CNT, 32'hAABB_CCDD, 4'b0100, 1'b1,
                32'h1122_3344};
    tbl[7]  = '{A_CNT,  32'h0, 4'h0, 1'b1, 32'h11BB_3344};
    tbl[8]  = '{A_RLD, 32'hFFFF_FFFF, 4'b0011, 1'b1, 32'h0};
    tbl[9]  = '{A_RLD,  32'h0, 4'h0, 1'b1, 32'h0000_FFFF};
    tbl[10] = '{BASE + 32'h40, 32'h0, 4'h0, 1'b1, 32'h0};
    tbl[11] = '{A_CTRL, 32'hFFFF_FFF8, 4'hF, 1'b1, 32'h0};
    tbl[12] = '{A_CTRL, 32'h0000_0707, 4'b1110, 1'b1, 32'h0};
    tbl[13] = '{A_CTRL, 32'h0, 4'h0, 1'b1, 32'h0};
    tbl[14] = '{A_PRE, 32'hFFFF_1234, 4'b0011, 1'b1, 32'h0};
    tbl[15] = '{A_PRE, 32'h0, 4'h0, 1'b1, pre_rb};
    tbl[16] = '{BASE + 32'h100, 32'h0, 4'h0, 1'b0, 32'h0};
    tbl[17] = '{BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};

    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ready", 32'(iomem_ready), 32'd0);

    for (int i = 0; i < 18; i++) begin
      step(1'b1, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      check($sformatf("tbl%0d_ready", i), 32'(last_rdy),
            32'(tbl[i].rdy));
      check($sformatf("tbl%0d_rdata", i), last_rd,
            tbl[i].rdata);
      idle();
    end

    // One-shot expiry and irq latency
    do_reset();
    wr(A_CNT, 32'd5);
    step(1'b1, A_CTRL, 32'h5, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      idle();
      check($sformatf("oneshot_irq_k%0d", k), 32'(irq),
            32'(k >= 6));
    end
    rd("oneshot_count", A_CNT, 32'd0);
    rd("oneshot_ctrl", A_CTRL, 32'h4);
    rd("oneshot_exp", A_STAT, 32'd1);
    wr(A_STAT, 32'd1);
    rd("w1c_exp", A_STAT, 32'd0);

    // Auto-reload period and W1C colliding with expiry
    do_reset();
    wr(A_RLD, 32'd3);
    wr(A_CNT, 32'd3);
    step(1'b1, A_CTRL, 32'h7, 4'hF);
    idle();
    step(1'b1, A_CNT, 32'd0, 4'd0);
    check("ar_cnt_a", last_rd, 32'd2);
    idle();
    step(1'b1, A_CNT, 32'd0, 4'd0);
    check("ar_cnt_b", last_rd, 32'd3);
    idle();
    step(1'b1, A_CNT, 32'd0, 4'd0);
    check("ar_cnt_c", last_rd, 32'd1);
    idle();
    step(1'b1, A_STAT, 32'd1, 4'b0001);
    idle();
    check("ar_cleared_irq", 32'(irq), 32'd0);
    idle();
    idle();
    step(1'b1, A_STAT, 32'd1, 4'b0001);
    idle();
    check("ar_setwins_irq", 32'(irq), 32'd1);
    step(1'b1, A_STAT, 32'd0, 4'd0);
    check("ar_setwins_exp", last_rd, 32'd1);
    idle();
    wr(A_CTRL, 32'd0);

`ifdef PICOSOC_IOMEM_TIMER_PRESCALE_EN
    do_reset();
    wr(A_PRE, 32'd3);
    wr(A_CNT, 32'd2);
    step(1'b1, A_CTRL, 32'h5, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      idle();
      check($sformatf("pre_irq_k%0d", k), 32'(irq),
            32'(k >= 9));
    end
`endif

    // Reset in the middle of a count with a read pending
    do_reset();
    wr(A_CNT, 32'd10);
    step(1'b1, A_CTRL, 32'h5, 4'hF);
    idle();
    idle();
    resetn = 1'b0;
    step(1'b1, A_CNT, 32'd0, 4'd0);
    check("midrst_ready", 32'(last_rdy), 32'd0);
    resetn = 1'b1;
    rd("midrst_ctrl", A_CTRL, 32'd0);
    rd("midrst_count", A_CNT, 32'd0);
    rd("midrst_reload", A_RLD, 32'd0);
    rd("midrst_stat", A_STAT, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic v;
      logic [31:0] a, d;
      logic [3:0] ws;
      int sel;
      v = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel <= 5)
        a = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
      else if (sel == 6) a = BASE + 32'h40;
      else if (sel == 7) a = BASE + 32'h100;
      else if (sel == 8) a = $urandom;
      else a = A_STAT;
      if (sel == 4) d = 32'($urandom_range(0, 3));
      else if (sel == 0) d = 32'($urandom_range(0, 7));
      else if ($urandom_range(0, 7) == 0) d = $urandom;
      else d = 32'($urandom_range(0, 12));
      ws = ($urandom_range(0, 2) == 0) ? 4'd0 :
           4'($urandom_range(1, 15));
      if ($urandom_range(0, 599) == 0) resetn = 1'b0;
      step(v, a, d, ws);
      resetn = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
